cnt32_bank_ctrl: RTL and testbench

//  Schedules CNT_NUM 32-bit statistics counters onto one shared 32-bit adder.
//  Per-counter event pulses build up in small pending accumulators. A

---
 rtl/cnt_bank_pkg.sv | 26 ++
 rtl/cnt_rr_arb.sv | 42 ++++
 rtl/cnt32_bank_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cnt32_bank_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_bank_pkg.sv
// cnt_bank_pkg
// Shared definitions for the statistics counter bank:
//   CNT_WIDTH    - width of every statistics counter (and of the shared adder)
//   cpu_state_e  - CPU read FSM encoding (IDLE -> ACC -> ACK)
//   rr_wrap      - helper that folds base+offset back into 0..n-1
package cnt_bank_pkg;

    localparam int CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ACK  = 2'd2
    } cpu_state_e;

    // base and off are both below n, so one conditional subtract is enough.
    function automatic int rr_wrap(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/cnt_rr_arb.sv
// cnt_rr_arb
// Round-robin picker: grants the first requester at or after i_ptr,
// wrapping around the N-entry request vector.
// Ports:
//   i_req      N   request vector (one bit per counter with pending events)
//   i_ptr      PW  search start position
//   i_en       1   picker enable; no grant while low
//   o_gnt      N   one-hot grant
//   o_gnt_idx  PW  index of the granted requester
//   o_vld      1   a grant was made this cycle
module cnt_rr_arb
    import cnt_bank_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_gnt_idx,
    output logic          o_vld
);

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_vld     = 1'b0;
        // Walk from the farthest offset down to offset 0 so the requester
        // closest to i_ptr is the last (winning) assignment.
        for (int k = N - 1; k >= 0; k--) begin
            if (i_en && i_req[rr_wrap(int'(i_ptr), k, N)]) begin
                o_vld     = 1'b1;
                o_gnt_idx = PW'(rr_wrap(int'(i_ptr), k, N));
            end
        end
        if (o_vld) begin
            o_gnt[o_gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cnt32_bank_ctrl.sv
// cnt32_bank_ctrl
// CNT_NUM 32-bit statistics counters sharing a single adder. Event strobes
// build up in saturating pending accumulators; a round-robin scheduler
// flushes one accumulator per cycle into its counter. A 4-phase CPU read
// port returns a coherent counter+pending value, optionally clearing it.
// Ports:
//   clks          1           clock
//   reset         1           synchronous reset, active low
//   cnt_inc       CNT_NUM     per-counter event strobes
//   cnt_clr_all   1           clear every counter, pend and overflow flag
//   cpu_rd_req    1           read request (level, held until ack seen)
//   cpu_rd_clr    1           clear the counter after the read
//   cpu_addr      ADDR_WIDTH  read address
//   cpu_rd_ack    1           read acknowledge
//   cpu_data_out  32          read data, valid while ack is high
//   pend_ovf      CNT_NUM     sticky pending-accumulator overflow
//   dbg_state     2           CPU read FSM state
// Handshake: req rises and is held with addr/clr stable; the cycle after req
// is sampled is the access (ACC) slot; ack then rises with data and stays
// high while req is high; ack drops on the edge after req falls.
module cnt32_bank_ctrl
    import cnt_bank_pkg::*;
#(
    parameter int                    CNT_NUM    = 8,
    parameter int                    ADDR_WIDTH = 13,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h100,
    parameter int                    PEND_WIDTH = 4
) (
    input  logic                  clks,
    input  logic                  reset,
    input  logic [CNT_NUM-1:0]    cnt_inc,
    input  logic                  cnt_clr_all,
    input  logic                  cpu_rd_req,
    input  logic                  cpu_rd_clr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic                  cpu_rd_ack,
    output logic [CNT_WIDTH-1:0]  cpu_data_out,
    output logic [CNT_NUM-1:0]    pend_ovf,
    output cpu_state_e            dbg_state
);

    localparam int PW = $clog2(CNT_NUM);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    logic [CNT_NUM-1:0][CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_NUM-1:0][PEND_WIDTH-1:0] r_pend;
    logic [CNT_NUM-1:0]                 r_ovf;
    logic [PW-1:0]                      r_ptr;
    logic [CNT_WIDTH-1:0]               r_data;
    logic                               r_ack;
    cpu_state_e                         r_state;

    cpu_state_e                         w_state_nxt;
    logic [CNT_NUM-1:0]                 w_req;
    logic [CNT_NUM-1:0]                 w_gnt;
    logic [PW-1:0]                      w_gnt_idx;
    logic                               w_gnt_vld;
    logic                               w_arb_en;
    logic [ADDR_WIDTH-1:0]              w_off;
    logic                               w_hit;
    logic [PW-1:0]                      w_idx;
    logic [PW-1:0]                      w_sel;
    logic [CNT_WIDTH-1:0]               w_sum;
    logic [CNT_NUM-1:0]                 w_flush;
    logic [PW-1:0]                      w_ptr_nxt;

    // ---------------- CPU read FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (cpu_rd_req) w_state_nxt = ST_ACC;
            ST_ACC:  w_state_nxt = ST_ACK;
            ST_ACK:  if (!cpu_rd_req) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- address decode ----------------
    // Addresses below BASE_ADDR wrap to large offsets and miss naturally.
    assign w_off = cpu_addr - BASE_ADDR;
    assign w_hit = (w_off < ADDR_WIDTH'(CNT_NUM));
    assign w_idx = w_off[PW-1:0];

    // ---------------- scheduler ----------------
    always_comb begin
        for (int i = 0; i < CNT_NUM; i++) begin
            w_req[i] = (r_pend[i] != '0);
        end
    end

    // The ACC cycle belongs to the CPU; a global clear also idles the scheduler.
    assign w_arb_en = (r_state != ST_ACC) && !cnt_clr_all;

    cnt_rr_arb #(
        .N  (CNT_NUM),
        .PW (PW)
    ) u_arb (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .i_en      (w_arb_en),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_vld     (w_gnt_vld)
    );

    assign w_ptr_nxt = (w_gnt_idx == PW'(CNT_NUM - 1)) ? '0 : w_gnt_idx + 1'b1;

    // ---------------- shared adder ----------------
    assign w_sel = (r_state == ST_ACC) ? w_idx : w_gnt_idx;
    assign w_sum = r_cnt[w_sel] + CNT_WIDTH'(r_pend[w_sel]);

    // Accumulator being drained this cycle, by the CPU slot or the scheduler.
    always_comb begin
        w_flush = '0;
        if (r_state == ST_ACC) begin
            if (w_hit) w_flush[w_idx] = 1'b1;
        end else if (w_gnt_vld) begin
            w_flush = w_gnt;
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clks) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_pend  <= '0;
            r_ovf   <= '0;
            r_ptr   <= '0;
            r_data  <= '0;
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= (w_state_nxt == ST_ACK);
            if (cnt_clr_all) begin
                r_cnt  <= '0;
                r_pend <= '0;
                r_ovf  <= '0;
                if (r_state == ST_ACC) r_data <= '0;
            end else begin
                // A drained accumulator restarts from this cycle's strobe, so
                // an event coinciding with a flush is never lost.
                for (int i = 0; i < CNT_NUM; i++) begin
                    if (w_flush[i]) begin
                        r_pend[i] <= PEND_WIDTH'(cnt_inc[i]);
                    end else if (cnt_inc[i]) begin
                        if (r_pend[i] == PEND_MAX) r_ovf[i] <= 1'b1;
                        else                       r_pend[i] <= r_pend[i] + 1'b1;
                    end
                end
                if (r_state == ST_ACC) begin
                    if (w_hit) begin
                        r_data       <= w_sum;
                        r_cnt[w_idx] <= cpu_rd_clr ? '0 : w_sum;
                    end else begin
                        r_data <= '0;
                    end
                end else if (w_gnt_vld) begin
                    r_cnt[w_gnt_idx] <= w_sum;
                    r_ptr            <= w_ptr_nxt;
                end
            end
        end
    end

    assign cpu_rd_ack   = r_ack;
    assign cpu_data_out = r_data;
    assign pend_ovf     = r_ovf;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_cnt32_bank_ctrl.sv
module tb_cnt32_bank_ctrl;
    import cnt_bank_pkg::*;

    localparam logic [12:0] BASE = 13'h100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  cnt_inc;
    logic        cnt_clr_all;
    logic        cpu_rd_req;
    logic        cpu_rd_clr;
    logic [12:0] cpu_addr;
    logic        cpu_rd_ack;
    logic [31:0] cpu_data_out;
    logic [7:0]  pend_ovf;
    cpu_state_e  dbg_state;

    // Second instance with narrow accumulators for the saturation case.
    logic [7:0]  inc2;
    logic        clr2;
    logic        ack2;
    logic [31:0] data2;
    logic [7:0]  ovf2;
    cpu_state_e  state2;

    cnt32_bank_ctrl dut (
        .clks         (clk),
        .reset        (rst_n),
        .cnt_inc      (cnt_inc),
        .cnt_clr_all  (cnt_clr_all),
        .cpu_rd_req   (cpu_rd_req),
        .cpu_rd_clr   (cpu_rd_clr),
        .cpu_addr     (cpu_addr),
        .cpu_rd_ack   (cpu_rd_ack),
        .cpu_data_out (cpu_data_out),
        .pend_ovf     (pend_ovf),
        .dbg_state    (dbg_state)
    );

    cnt32_bank_ctrl #(.PEND_WIDTH(2)) dut2 (
        .clks         (clk),
        .reset        (rst_n),
        .cnt_inc      (inc2),
        .cnt_clr_all  (clr2),
        .cpu_rd_req   (1'b0),
        .cpu_rd_clr   (1'b0),
        .cpu_addr     (13'h0),
        .cpu_rd_ack   (ack2),
        .cpu_data_out (data2),
        .pend_ovf     (ovf2),
        .dbg_state    (state2)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_inc(input logic [7:0] vec, input int cycles);
        cnt_inc = vec;
        step(cycles);
        cnt_inc = '0;
    endtask

    task automatic pulse_clr_all();
        cnt_clr_all = 1'b1;
        step(1);
        cnt_clr_all = 1'b0;
    endtask

    // Full 4-phase read. acc_inc / acc_clr drive cnt_inc / cnt_clr_all during the ACC cycle.
    task automatic do_read(input logic [12:0] addr, input logic clr, input logic [7:0] acc_inc,
                           input logic acc_clr, output logic [31:0] data);
        int waited;
        cpu_addr   = addr;
        cpu_rd_clr = clr;
        cpu_rd_req = 1'b1;
        step(1);                        // req sampled, FSM now in ACC
        chk("ack_low_in_acc", {31'b0, cpu_rd_ack}, 32'd1 - 32'd1);
        cnt_inc     = acc_inc;
        cnt_clr_all = acc_clr;
        step(1);                        // ACC -> ACK
        cnt_inc     = '0;
        cnt_clr_all = 1'b0;
        chk("ack_latency", {31'b0, cpu_rd_ack}, 32'd1);
        waited = 0;
        while (!cpu_rd_ack && waited < 8) begin
            step(1);
            waited++;
        end
        data = cpu_data_out;
        step(1);                        // ack must be held while req stays high
        chk("ack_held", {31'b0, cpu_rd_ack}, 32'd1);
        chk("data_held", cpu_data_out, data);
        cpu_rd_req = 1'b0;
        step(1);
        chk("ack_drop", {31'b0, cpu_rd_ack}, 32'd0);
        cpu_rd_clr = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [12:0] addr;
        logic        clr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t tbl[12];

    logic [31:0]       rd;
    logic [7:0][31:0]  preload;

    initial begin
        // reads after 1000 cycles of every strobe high
        for (int i = 0; i < 8; i++) begin
            tbl[i].addr = BASE + 13'(i);
            tbl[i].clr  = 1'b0;
            tbl[i].exp  = 32'd1000;
        end
        tbl[8]  = '{addr: BASE - 13'd1, clr: 1'b0, exp: 32'd0};
        tbl[9]  = '{addr: BASE + 13'd8, clr: 1'b0, exp: 32'd0};
        tbl[10] = '{addr: BASE + 13'd3, clr: 1'b1, exp: 32'd1000};
        tbl[11] = '{addr: BASE + 13'd3, clr: 1'b0, exp: 32'd0};

        rst_n = 1'b0; cnt_inc = '0; cnt_clr_all = 1'b0;
        cpu_rd_req = 1'b0; cpu_rd_clr = 1'b0; cpu_addr = '0;
        inc2 = '0; clr2 = 1'b0;
        step(3);
        chk("rst_ack", {31'b0, cpu_rd_ack}, 32'd0);
        chk("rst_data", cpu_data_out, 32'd0);
        chk("rst_ovf", {24'b0, pend_ovf}, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        rst_n = 1'b1;
        step(1);

        // all counters busy, accumulators must keep up without overflow
        run_inc(8'hFF, 1000);
        chk("busy_no_ovf", {24'b0, pend_ovf}, 32'd0);
        for (int v = 0; v < 12; v++) begin
            do_read(tbl[v].addr, tbl[v].clr, 8'h00, 1'b0, rd);
            chk($sformatf("tbl_rd_%0d", v), rd, tbl[v].exp);
        end

        // single counter, read twice: a plain read must not disturb the value
        pulse_clr_all();
        run_inc(8'h04, 100);
        step(8);
        do_read(BASE + 13'd2, 1'b0, 8'h00, 1'b0, rd);
        chk("single_rd", rd, 32'd100);
        do_read(BASE + 13'd2, 1'b0, 8'h00, 1'b0, rd);
        chk("single_rd_again", rd, 32'd100);

        // clear-on-read with an event in the ACC cycle: event survives in pend
        pulse_clr_all();
        run_inc(8'h20, 40);
        do_read(BASE + 13'd5, 1'b1, 8'h20, 1'b0, rd);
        chk("cor_rd", rd, 32'd40);
        step(4);
        do_read(BASE + 13'd5, 1'b0, 8'h00, 1'b0, rd);
        chk("cor_left", rd, 32'd1);

        // 32-bit wrap
        pulse_clr_all();
        preload    = '0;
        preload[0] = 32'hFFFF_FFFE;
        force dut.r_cnt = preload;
        step(1);
        release dut.r_cnt;
        run_inc(8'h01, 3);
        step(4);
        do_read(BASE, 1'b0, 8'h00, 1'b0, rd);
        chk("wrap_rd", rd, 32'd1);

        // pend saturation on the 2-bit instance; a lone counter never overflows
        chk("ovf2_rst", {24'b0, ovf2}, 32'd0);
        inc2 = 8'h10;
        step(30);
        inc2 = '0;
        step(2);
        chk("ovf2_single", {24'b0, ovf2}, 32'd0);
        inc2 = 8'hFF;
        step(20);
        inc2 = '0;
        step(4);
        chk("ovf2_sat", {24'b0, ovf2}, 32'hFF);
        clr2 = 1'b1;
        step(1);
        clr2 = 1'b0;
        chk("ovf2_clr", {24'b0, ovf2}, 32'd0);

        // global clear landing in the ACC cycle
        pulse_clr_all();
        run_inc(8'h06, 10);
        do_read(BASE + 13'd1, 1'b0, 8'h00, 1'b1, rd);
        chk("clr_in_acc_data", rd, 32'd0);
        do_read(BASE + 13'd1, 1'b0, 8'h00, 1'b0, rd);
        chk("clr_in_acc_c1", rd, 32'd0);
        do_read(BASE + 13'd2, 1'b0, 8'h00, 1'b0, rd);
        chk("clr_in_acc_c2", rd, 32'd0);

        // reset while ack is high
        run_inc(8'h10, 5);
        cpu_addr   = BASE + 13'd4;
        cpu_rd_req = 1'b1;
        step(2);
        chk("pre_rst_ack", {31'b0, cpu_rd_ack}, 32'd1);
        chk("pre_rst_data", cpu_data_out, 32'd5);
        rst_n = 1'b0;
        step(1);
        chk("mid_rst_ack", {31'b0, cpu_rd_ack}, 32'd0);
        chk("mid_rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        rst_n      = 1'b1;
        cpu_rd_req = 1'b0;
        step(2);
        do_read(BASE + 13'd4, 1'b0, 8'h00, 1'b0, rd);
        chk("post_rst_c4", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
